// File: rtl/cache_control.sv
// Two-way cache controller: serves hits in IDLE, evicts dirty victims, refills lines, and keeps hit/miss statistics.
// Latency: a hit completes in the cycle it is presented; a miss completes in IDLE right after the refill.
// Backpressure: the CPU holds its request until mem_resp; WRITEBACK and ALLOCATE each hold until pmem_resp.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   mem_read, mem_write, mem_resp CPU request and completion
//   hit0, hit1, lru, dirty_lru    datapath status
//   load_line .. pmem_addr_sel    datapath control (combinational)
//   pmem_read, pmem_write, pmem_resp  memory-side handshake
//   clear_counts, hit_count, miss_count  statistics (registered, saturating)
module cache_control (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_read,
    input  logic        mem_write,
    output logic        mem_resp,
    input  logic        hit0,
    input  logic        hit1,
    input  logic        lru,
    input  logic        dirty_lru,
    output logic        load_line,
    output logic        line_way,
    output logic        line_src,
    output logic        load_tag,
    output logic        set_valid,
    output logic        set_dirty,
    output logic        clr_dirty,
    output logic        load_lru,
    output logic        lru_in,
    output logic        pmem_addr_sel,
    output logic        pmem_read,
    output logic        pmem_write,
    input  logic        pmem_resp,
    input  logic        clear_counts,
    output logic [15:0] hit_count,
    output logic [15:0] miss_count
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WRITEBACK = 2'd1,
        ALLOCATE  = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic        refill_q, refill_d;
    logic [15:0] hit_count_q, hit_count_d;
    logic [15:0] miss_count_q, miss_count_d;

    logic        req;
    logic        is_write;
    logic        hit;
    logic        hit_way;
    logic        hit_inc;
    logic        miss_inc;

    always_comb begin
        req      = mem_read | mem_write;
        // A simultaneous read and write is handled as a write.
        is_write = mem_write;
        hit      = hit0 | hit1;
        // Way 0 wins when both ways report a hit.
        hit_way  = ~hit0;

        state_d       = state_q;
        refill_d      = refill_q;
        hit_inc       = 1'b0;
        miss_inc      = 1'b0;
        mem_resp      = 1'b0;
        load_line     = 1'b0;
        line_way      = 1'b0;
        line_src      = 1'b0;
        load_tag      = 1'b0;
        set_valid     = 1'b0;
        set_dirty     = 1'b0;
        clr_dirty     = 1'b0;
        load_lru      = 1'b0;
        lru_in        = 1'b0;
        pmem_addr_sel = 1'b0;
        pmem_read     = 1'b0;
        pmem_write    = 1'b0;

        case (state_q)
            IDLE: begin
                if (req) begin
                    if (hit) begin
                        mem_resp = 1'b1;
                        load_lru = 1'b1;
                        lru_in   = ~hit_way;
                        if (is_write) begin
                            load_line = 1'b1;
                            line_way  = hit_way;
                            line_src  = 1'b0;
                            set_dirty = 1'b1;
                        end
                        // The completion that follows a refill belongs to the
                        // miss already counted, so it is not a hit.
                        if (refill_q) begin
                            refill_d = 1'b0;
                        end else begin
                            hit_inc = 1'b1;
                        end
                    end else begin
                        miss_inc = 1'b1;
                        state_d  = dirty_lru ? WRITEBACK : ALLOCATE;
                    end
                end else begin
                    // Request abandoned during the miss: forget the refill.
                    refill_d = 1'b0;
                end
            end
            WRITEBACK: begin
                pmem_write    = 1'b1;
                pmem_addr_sel = 1'b1;
                line_way      = lru;
                if (pmem_resp) begin
                    state_d = ALLOCATE;
                end
            end
            ALLOCATE: begin
                pmem_read     = 1'b1;
                pmem_addr_sel = 1'b0;
                if (pmem_resp) begin
                    load_line = 1'b1;
                    line_way  = lru;
                    line_src  = 1'b1;
                    load_tag  = 1'b1;
                    set_valid = 1'b1;
                    clr_dirty = 1'b1;
                    state_d   = IDLE;
                    refill_d  = 1'b1;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Reset blanks every control output at once, even before the state flop settles.
        if (rst) begin
            mem_resp      = 1'b0;
            load_line     = 1'b0;
            line_way      = 1'b0;
            line_src      = 1'b0;
            load_tag      = 1'b0;
            set_valid     = 1'b0;
            set_dirty     = 1'b0;
            clr_dirty     = 1'b0;
            load_lru      = 1'b0;
            lru_in        = 1'b0;
            pmem_addr_sel = 1'b0;
            pmem_read     = 1'b0;
            pmem_write    = 1'b0;
        end
    end

    // Saturating counters; a clear wins over an increment in the same cycle.
    always_comb begin
        hit_count_d  = hit_count_q;
        miss_count_d = miss_count_q;
        if (clear_counts) begin
            hit_count_d  = 16'h0000;
            miss_count_d = 16'h0000;
        end else begin
            if (hit_inc && (hit_count_q != 16'hFFFF)) begin
                hit_count_d = hit_count_q + 16'h0001;
            end
            if (miss_inc && (miss_count_q != 16'hFFFF)) begin
                miss_count_d = miss_count_q + 16'h0001;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            refill_q     <= 1'b0;
            hit_count_q  <= 16'h0000;
            miss_count_q <= 16'h0000;
        end else begin
            state_q      <= state_d;
            refill_q     <= refill_d;
            hit_count_q  <= hit_count_d;
            miss_count_q <= miss_count_d;
        end
    end

    assign hit_count  = hit_count_q;
    assign miss_count = miss_count_q;

endmodule

// File: tb/tb_cache_control.sv
module tb_cache_control;

    logic        clk;
    logic        rst;
    logic        mem_read, mem_write, mem_resp;
    logic        hit0, hit1, lru, dirty_lru;
    logic        load_line, line_way, line_src, load_tag, set_valid;
    logic        set_dirty, clr_dirty, load_lru, lru_in, pmem_addr_sel;
    logic        pmem_read, pmem_write, pmem_resp;
    logic        clear_counts;
    logic [15:0] hit_count, miss_count;

    int tests_run = 0;
    int tests_failed = 0;

    // Expected hit completions: bit1 = write, bit0 = way that hits.
    logic [1:0] sb[$];

    logic [12:0] ctrl;
    assign ctrl = {load_line, line_way, line_src, load_tag, set_valid, set_dirty,
                   clr_dirty, load_lru, lru_in, pmem_addr_sel, mem_resp,
                   pmem_read, pmem_write};

    cache_control dut (
        .clk(clk), .rst(rst),
        .mem_read(mem_read), .mem_write(mem_write), .mem_resp(mem_resp),
        .hit0(hit0), .hit1(hit1), .lru(lru), .dirty_lru(dirty_lru),
        .load_line(load_line), .line_way(line_way), .line_src(line_src),
        .load_tag(load_tag), .set_valid(set_valid), .set_dirty(set_dirty),
        .clr_dirty(clr_dirty), .load_lru(load_lru), .lru_in(lru_in),
        .pmem_addr_sel(pmem_addr_sel), .pmem_read(pmem_read),
        .pmem_write(pmem_write), .pmem_resp(pmem_resp),
        .clear_counts(clear_counts), .hit_count(hit_count), .miss_count(miss_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests_run++;
        if (obs !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One hit request held for one cycle; its completion is checked by the monitor.
    task automatic do_hit(input logic rd, input logic wr, input logic h0, input logic h1);
        mem_read  = rd;
        mem_write = wr;
        hit0      = h0;
        hit1      = h1;
        sb.push_back({wr, h0 ? 1'b0 : 1'b1});
        @(negedge clk);
        tick();
        mem_read  = 1'b0;
        mem_write = 1'b0;
        hit0      = 1'b0;
        hit1      = 1'b0;
    endtask

    // Completion monitor plus the read/write exclusivity check, every cycle.
    always @(negedge clk) begin
        logic [1:0] r;
        chk("pmem_excl", 32'(pmem_read & pmem_write), 32'd0);
        if (mem_resp) begin
            if (sb.size() == 0) begin
                chk("resp_unexpected", 32'd1, 32'd0);
            end else begin
                r = sb.pop_front();
                chk("resp_lru", 32'({load_lru, lru_in}), 32'({1'b1, ~r[0]}));
                chk("resp_wr", 32'({load_line, set_dirty, line_src}), 32'({r[1], r[1], 1'b0}));
                if (r[1]) chk("resp_way", 32'(line_way), 32'(r[0]));
            end
        end
    end

    initial begin
        // Reset held with a live hit request and pmem_resp: everything must stay quiet.
        rst = 1'b1; clear_counts = 1'b0;
        mem_read = 1'b1; mem_write = 1'b1; hit0 = 1'b1; hit1 = 1'b0;
        lru = 1'b0; dirty_lru = 1'b0; pmem_resp = 1'b1;
        #2;
        chk("rst_ctrl", 32'(ctrl), 32'd0);
        chk("rst_hits", 32'(hit_count), 32'd0);
        chk("rst_miss", 32'(miss_count), 32'd0);
        #4;
        mem_read = 1'b0; mem_write = 1'b0; hit0 = 1'b0; pmem_resp = 1'b0;
        #1 rst = 1'b0;
        @(negedge clk);
        chk("idle_ctrl", 32'(ctrl), 32'd0);
        tick();

        // Read hit on way 1, then a write with both ways hitting (treated as write, way 0).
        do_hit(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("rd_hit_cnt", 32'(hit_count), 32'd1);
        tick();
        do_hit(1'b1, 1'b1, 1'b1, 1'b1);
        @(negedge clk);
        chk("wr_hit_cnt", 32'(hit_count), 32'd2);
        chk("wr_hit_miss", 32'(miss_count), 32'd0);
        tick();

        // Clean read miss, victim way 1, memory answers on the third ALLOCATE cycle.
        mem_read = 1'b1; lru = 1'b1; dirty_lru = 1'b0;
        @(negedge clk);
        chk("cm_idle_pmem", 32'({pmem_read, pmem_write}), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            pmem_resp = (i == 2);
            @(negedge clk);
            chk("cm_alloc_rd", 32'({pmem_read, pmem_write, pmem_addr_sel}), 32'b100);
            if (i == 2)
                chk("cm_fill", 32'({load_line, line_way, line_src, load_tag, set_valid, clr_dirty}), 32'b111111);
            else
                chk("cm_wait", 32'(load_line), 32'd0);
            tick();
        end
        pmem_resp = 1'b0;
        do_hit(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("cm_hits", 32'(hit_count), 32'd2);
        chk("cm_miss", 32'(miss_count), 32'd1);
        tick();

        // Dirty write miss: writeback of way 1, then refill, then write completion.
        mem_write = 1'b1; lru = 1'b1; dirty_lru = 1'b1;
        @(negedge clk);
        chk("dm_idle_pmem", 32'({pmem_read, pmem_write}), 32'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            pmem_resp = (i == 2);
            @(negedge clk);
            chk("dm_wb", 32'({pmem_write, pmem_addr_sel, line_way, pmem_read, load_line}), 32'b11100);
            tick();
        end
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("dm_alloc", 32'({pmem_read, pmem_addr_sel, pmem_write, load_line}), 32'b1000);
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("dm_fill", 32'({load_line, line_src, line_way}), 32'b111);
        tick();
        pmem_resp = 1'b0; dirty_lru = 1'b0;
        do_hit(1'b0, 1'b1, 1'b0, 1'b1);
        @(negedge clk);
        chk("dm_hits", 32'(hit_count), 32'd2);
        chk("dm_miss", 32'(miss_count), 32'd2);
        tick();

        // Request dropped mid-ALLOCATE: transaction finishes, refill clears on idle.
        mem_read = 1'b1; lru = 1'b0;
        @(negedge clk);
        tick();
        mem_read = 1'b0;
        @(negedge clk);
        chk("drop_pread", 32'(pmem_read), 32'd1);
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("drop_fill", 32'({load_line, line_src}), 32'b11);
        tick();
        pmem_resp = 1'b0;
        @(negedge clk);
        chk("drop_idle", 32'(ctrl), 32'd0);
        tick();
        pmem_resp = 1'b1;
        @(negedge clk);
        chk("idle_presp", 32'(ctrl), 32'd0);
        tick();
        pmem_resp = 1'b0;
        do_hit(1'b1, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("drop_hits", 32'(hit_count), 32'd3);
        chk("drop_miss", 32'(miss_count), 32'd3);
        tick();

        // Saturation: 65,537 more read hits push past 16'hFFFF; then clear with a hit.
        mem_read = 1'b1; hit0 = 1'b1;
        for (int i = 0; i < 65537; i++) begin
            sb.push_back(2'b00);
            @(negedge clk);
            tick();
        end
        @(negedge clk);
        chk("sat_hits", 32'(hit_count), 32'hFFFF);
        sb.push_back(2'b00);
        tick();
        clear_counts = 1'b1;
        sb.push_back(2'b00);
        @(negedge clk);
        tick();
        clear_counts = 1'b0; mem_read = 1'b0; hit0 = 1'b0;
        @(negedge clk);
        chk("clr_hits", 32'(hit_count), 32'd0);
        chk("clr_miss", 32'(miss_count), 32'd0);
        tick();

        // Asynchronous reset in the middle of ALLOCATE.
        mem_read = 1'b1; lru = 1'b0; dirty_lru = 1'b0;
        @(negedge clk);
        tick();
        #1;
        chk("ar_pre_pread", 32'(pmem_read), 32'd1);
        chk("ar_pre_miss", 32'(miss_count), 32'd1);
        #1 rst = 1'b1;
        #1;
        chk("ar_pread", 32'(pmem_read), 32'd0);
        chk("ar_ctrl", 32'(ctrl), 32'd0);
        chk("ar_miss", 32'(miss_count), 32'd0);
        chk("ar_hits", 32'(hit_count), 32'd0);
        mem_read = 1'b0;
        #2 rst = 1'b0;
        @(negedge clk);
        chk("ar_idle", 32'(ctrl), 32'd0);
        tick();
        do_hit(1'b1, 1'b0, 1'b0, 1'b1);
        @(negedge clk);
        chk("ar_post_hits", 32'(hit_count), 32'd1);

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
